// File: rtl/detect_pkg.sv
// Shared constants and helpers for the serial pattern detector family.
package detect_pkg;

  // Values for the MEALY_FSM parameter.
  localparam bit MODE_MEALY = 1'b1;
  localparam bit MODE_MOORE = 1'b0;

  // Values for the OVERLAP parameter.
  localparam bit OVERLAP_ON  = 1'b1;
  localparam bit OVERLAP_OFF = 1'b0;

  // Width needed to hold a pattern length in the range 0..pattern_w.
  function automatic int unsigned len_w(input int unsigned pattern_w);
    return $clog2(pattern_w + 1);
  endfunction

endpackage

// File: rtl/detect_pattern_if.sv
// Stream, configuration and status bundle of the pattern detector.
interface detect_pattern_if
  import detect_pkg::*;
#(
  parameter int unsigned PATTERN_W = 8,
  parameter int unsigned COUNT_W   = 16
) ();

  localparam int unsigned LEN_W = len_w(PATTERN_W);

  logic                 series_valid;
  logic                 series;
  logic                 cfg_load;
  logic [PATTERN_W-1:0] cfg_pattern;
  logic [LEN_W-1:0]     cfg_len;
  logic                 clr_count;
  logic                 detect;
  logic [COUNT_W-1:0]   match_count;
  logic                 cfg_err;

  // Stimulus side: drives the stream and configuration.
  modport master (
    output series_valid, series, cfg_load, cfg_pattern, cfg_len, clr_count,
    input  detect, match_count, cfg_err
  );

  // Detector side.
  modport slave (
    input  series_valid, series, cfg_load, cfg_pattern, cfg_len, clr_count,
    output detect, match_count, cfg_err
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear plus increment yields 1.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;

  // Next count: clear wins over hold, an event in the clear cycle still counts.
  always_comb begin
    w_count_next = r_count;
    if (clr) begin
      w_count_next = inc ? WIDTH'(1) : '0;
    end else if (inc && (r_count != '1)) begin
      w_count_next = r_count + WIDTH'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/detect_pattern.sv
// Programmable serial bit-pattern detector with run-time reload, input-valid
// gating, overlap policy and a saturating match counter.
module detect_pattern
  import detect_pkg::*;
#(
  parameter int unsigned          PATTERN_W       = 8,
  parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = PATTERN_W'(8'b0000_1011),
  parameter int unsigned          DEFAULT_LEN     = 4,
  parameter bit                   OVERLAP         = OVERLAP_ON,
  parameter bit                   MEALY_FSM       = MODE_MEALY,
  parameter int unsigned          COUNT_W         = 16
) (
  input logic            clk,
  input logic            rst,
  detect_pattern_if.slave bus
);

  localparam int unsigned LEN_W = len_w(PATTERN_W);

  logic [PATTERN_W-1:0] r_pat;
  logic [PATTERN_W-1:0] r_hist;
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     r_fill;
  logic                 r_detect;
  logic                 r_cfg_err;

  logic                 w_accept;
  logic                 w_cfg_ok;
  logic                 w_fill_ok;
  logic                 w_match;
  logic [PATTERN_W-1:0] w_cand;
  logic [PATTERN_W-1:0] w_mask;
  logic [LEN_W:0]       w_fill_inc;
  logic [LEN_W-1:0]     w_fill_next;
  logic                 w_unused_hist_msb;

  // A bit presented alongside a config load is dropped.
  assign w_accept = bus.series_valid & ~bus.cfg_load;
  assign w_cfg_ok = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_W'(PATTERN_W));

  // Candidate window including the incoming bit; only the low len bits count.
  assign w_cand     = {r_hist[PATTERN_W-2:0], bus.series};
  assign w_mask     = ~({PATTERN_W{1'b1}} << r_len);
  assign w_fill_inc = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
  assign w_fill_ok  = (w_fill_inc >= {1'b0, r_len});
  assign w_match    = w_accept && w_fill_ok && (((w_cand ^ r_pat) & w_mask) == '0);

  // The oldest history bit shifts out unused.
  assign w_unused_hist_msb = r_hist[PATTERN_W-1];

  // Fill level after an accepted bit: saturate at len, or restart after a match.
  always_comb begin
    w_fill_next = w_fill_inc[LEN_W-1:0];
    if (w_match && (OVERLAP == OVERLAP_OFF)) begin
      w_fill_next = '0;
    end else if (w_fill_ok) begin
      w_fill_next = r_len;
    end
  end

  // Config, history, fill, registered detect and config-error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat     <= DEFAULT_PATTERN;
      r_len     <= LEN_W'(DEFAULT_LEN);
      r_hist    <= '0;
      r_fill    <= '0;
      r_detect  <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= bus.cfg_load & ~w_cfg_ok;
      if (bus.cfg_load) begin
        r_detect <= 1'b0;
        if (w_cfg_ok) begin
          r_pat  <= bus.cfg_pattern;
          r_len  <= bus.cfg_len;
          r_hist <= '0;
          r_fill <= '0;
        end
      end else if (w_accept) begin
        r_hist   <= w_cand;
        r_fill   <= w_fill_next;
        r_detect <= w_match;
      end
    end
  end

  sat_counter #(
    .WIDTH (COUNT_W)
  ) u_match_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_match),
    .clr   (bus.clr_count),
    .count (bus.match_count)
  );

  assign bus.detect  = (MEALY_FSM == MODE_MEALY) ? w_match : r_detect;
  assign bus.cfg_err = r_cfg_err;

endmodule

// File: doc/detect_pattern.md
Name: detect_pattern

Overview:
- Programmable serial bit-pattern detector; parametrised successor of the fixed 4-bit "1011" Mealy/Moore detector.
- Pattern and length are set by parameter defaults and can be reloaded at run time.
- Adds input-valid gating, a selectable overlapping/non-overlapping match policy, and a saturating match counter.
- Sits on a 1-bit serial stream, e.g. as a frame/sync-word detector ahead of a deserialiser.

Parameters:
- PATTERN_W, 8, maximum pattern length in bits (>=2).
- DEFAULT_PATTERN, 8'b0000_1011, pattern loaded at reset; right-justified, bits [len-1:0] used.
- DEFAULT_LEN, 4, pattern length loaded at reset (1..PATTERN_W).
- OVERLAP, 1'b1, 1 = overlapping matches allowed; 0 = history restarts after each match.
- MEALY_FSM, 1'b1, 1 = combinational detect in the completing-bit cycle; 0 = registered (Moore) detect.
- COUNT_W, 16, width of match_count.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- series_valid  input  1  series carries a bit this cycle.
- series  input  1  serial data bit.
- cfg_load  input  1  load cfg_pattern/cfg_len this cycle.
- cfg_pattern  input  PATTERN_W  new pattern, right-justified.
- cfg_len  input  $clog2(PATTERN_W+1)  new pattern length.
- clr_count  input  1  clear match_count.
- detect  output  1  match indication (timing per MEALY_FSM).
- match_count  output  COUNT_W  number of matches, saturating.
- cfg_err  output  1  one-cycle pulse: rejected cfg_load.

Behaviour:
- Reset, synchronous and active-high:
  - pat = DEFAULT_PATTERN, len = DEFAULT_LEN.
  - History register hist (PATTERN_W bits) = 0, fill counter = 0.
  - detect = 0, match_count = 0, cfg_err = 0.
- Bit order: the first received bit compares against pat[len-1]; the newest bit compares against pat[0]. The default config matches stream 1,0,1,1.
- Accepted bit: series_valid=1 and cfg_load=0. Each accepted bit sets hist <= {hist[PATTERN_W-2:0], series} and fill <= min(fill+1, len). Non-accepted cycles leave hist and fill unchanged.
- match (internal, combinational): accepted bit AND fill >= len-1 AND {hist[len-2:0], series} == pat[len-1:0]. For len==1, match = accepted bit AND series == pat[0].
- OVERLAP=1: a match has no side effect on fill.
- OVERLAP=0: on a match, fill <= 0, so the next match needs len fresh accepted bits.
- MEALY_FSM=1: detect = match, combinational, same cycle as the completing bit.
- MEALY_FSM=0:
  - detect register <= match on every accepted bit; it holds its value across non-accepted cycles.
  - detect therefore rises one cycle after the completing bit and stays high until the next accepted bit.
  - cfg_load clears the detect register.
- Counter:
  - match_count increments on match in both modes and saturates at 2^COUNT_W-1.
  - clr_count with no match -> 0. clr_count and match in the same cycle -> 1.
- cfg_load:
  - If 1 <= cfg_len <= PATTERN_W: pat <= cfg_pattern, len <= cfg_len, fill <= 0, hist <= 0.
  - Otherwise the config is unchanged and cfg_err pulses high for 1 cycle.
  - A series bit presented in a cfg_load cycle is discarded: no match, no count.
  - Takes effect on the next cycle. match_count is unaffected.
- Reset mid-stream discards all history; the next match needs len fresh bits.
- Latency: Mealy 0 cycles, Moore 1 cycle, from the completing bit.

Decomposition:
- Package detect_pkg:
  - Function len_w(PATTERN_W) = $clog2(PATTERN_W+1).
  - Mode constants MODE_MEALY/MODE_MOORE and OVERLAP_ON/OVERLAP_OFF.
- Sub-module sat_counter (params WIDTH; ports clk, rst, inc, clr, count) for match_count; reusable by other detectors.
- Matching, history and config logic stay in detect_pattern.

Test Plan:
- Default config, Mealy, OVERLAP=1; accepted stream 1,0,1,1,0,1,1 -> detect high on bits 4 and 7 (same cycle); match_count=2.
- Same stream, OVERLAP=0 -> detect only on bit 4; match_count=1. Moore variant -> detect high the cycle after bit 4 until bit 5 arrives.
- Stream 1,0,1,1 with series_valid=0 gaps of 3 cycles between bits -> a single detect on bit 4 only; no spurious detect during gaps; count=1.
- cfg_load with cfg_pattern=8'b110, cfg_len=3, then stream 1,1,0,1,1,0 -> matches on bits 3 and 6. Separately, cfg_len=0 and cfg_len=9 -> cfg_err pulse, old pattern still matches 1011.
- COUNT_W=2, send 1011 five times non-overlapping -> count 1,2,3,3,3. Then clr_count coinciding with the next match -> count=1.
- Stream 1,0,1, then rst for 1 cycle, then 1 -> no detect, count=0. Following 0,1,1 -> detect on the final 1.
